// File: rtl/i2c_byte_master.sv
// i2c_byte_master
// Byte-level I2C bus master. Executes one command per i2c_ready window:
// optional start (or repeated start), optional byte write/read, optional stop,
// always in that order. Lines are open-drain: *_oe = 1 pulls the line low.
//
// Ports
//   CLK_I2C, RESET            clock, synchronous active-high reset
//   i2c_in[7:0]               byte to transmit, captured on command accept
//   i2c_start/write/read/end  command flags, sampled only while i2c_ready = 1
//   i2c_ready                 idle, able to accept a command
//   i2c_error                 sticky fault (NACK on write, byte with no open transaction)
//   i2c_rdata[7:0]            last byte read, i2c_rvalid pulses when it updates
//   scl_oe, sda_oe            1 = pull line low, 0 = release
//   scl_in, sda_in            pad readback
//
// Build option
//   I2C_CLOCK_STRETCH_EN: when defined, a quarter in which SCL is released holds
//   its counter at 0 while scl_in reads low (slave clock stretching).
//   Otherwise scl_in is ignored and all latencies are fixed.
//
// state | meaning
// IDLE  | ready, waiting for a command
// START | 4-quarter (repeated) start condition
// BIT   | 9 bit slots x 4 quarters (8 data MSB-first, then ACK)
// STOP  | 3-quarter stop condition
// HOLD  | single cycle before returning to IDLE
module i2c_byte_master #(
  parameter logic [15:0] QUARTER = 16'd125
) (
  input  logic       CLK_I2C,
  input  logic       RESET,
  input  logic [7:0] i2c_in,
  input  logic       i2c_start,
  input  logic       i2c_write,
  input  logic       i2c_read,
  input  logic       i2c_end,
  output logic       i2c_ready,
  output logic       i2c_error,
  output logic [7:0] i2c_rdata,
  output logic       i2c_rvalid,
  output logic       scl_oe,
  output logic       sda_oe,
  input  logic       scl_in,
  input  logic       sda_in
);

  typedef enum logic [2:0] {IDLE, START, BIT, STOP, HOLD} state_t;

  state_t      state_q, state_d;
  logic [15:0] qcnt_q, qcnt_d;
  logic [1:0]  phase_q, phase_d;
  logic [3:0]  bit_q, bit_d;
  logic        wr_q, wr_d, rd_q, rd_d, end_q, end_d, open_q, open_d;
  logic [7:0]  tx_q, tx_d, rx_q, rx_d, rdata_q, rdata_d;
  logic        scl_q, scl_d, sda_q, sda_d, err_q, err_d, rv_q, rv_d;
  logic        busy, stall, q_last, cmd_any;

  assign busy    = (state_q == START) || (state_q == BIT) || (state_q == STOP);
  assign cmd_any = i2c_start | i2c_write | i2c_read | i2c_end;

`ifdef I2C_CLOCK_STRETCH_EN
  // Only freeze at count 0 of a quarter where we have released SCL.
  assign stall = busy && !scl_q && !scl_in && (qcnt_q == 16'd0);
`else
  logic scl_in_unused;
  assign scl_in_unused = scl_in;
  assign stall = 1'b0;
`endif

  assign q_last = busy && !stall && (qcnt_q == QUARTER - 16'd1);

  always_comb begin
    state_d = state_q;
    qcnt_d  = qcnt_q;
    phase_d = phase_q;
    bit_d   = bit_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    end_d   = end_q;
    open_d  = open_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    rdata_d = rdata_q;
    scl_d   = scl_q;
    sda_d   = sda_q;
    err_d   = err_q;
    rv_d    = 1'b0;

    if (busy && !stall) qcnt_d = q_last ? 16'd0 : qcnt_q + 16'd1;

    unique case (state_q)
      IDLE: if (cmd_any) begin
        wr_d    = i2c_write;
        rd_d    = i2c_read & ~i2c_write;
        end_d   = i2c_end;
        tx_d    = i2c_in;
        qcnt_d  = 16'd0;
        phase_d = 2'd0;
        bit_d   = 4'd0;
        if (i2c_start) begin
          state_d = START;
          err_d   = 1'b0;
          open_d  = 1'b1;
          sda_d   = 1'b0;
        end else if (i2c_write || i2c_read) begin
          if (!open_q) begin
            state_d = HOLD;
            err_d   = 1'b1;
          end else begin
            state_d = BIT;
            scl_d   = 1'b1;
            sda_d   = i2c_write ? ~i2c_in[7] : 1'b0;
          end
        end else if (open_q) begin
          state_d = STOP;
          scl_d   = 1'b1;
          sda_d   = 1'b1;
        end else begin
          state_d = HOLD;
        end
      end

      START: if (q_last) begin
        phase_d = phase_q + 2'd1;
        if (phase_q == 2'd0)      scl_d = 1'b0;
        else if (phase_q == 2'd1) sda_d = 1'b1;
        else if (phase_q == 2'd2) scl_d = 1'b1;
        else if (wr_q || rd_q) begin
          state_d = BIT;
          bit_d   = 4'd0;
          scl_d   = 1'b1;
          sda_d   = wr_q ? ~tx_q[7] : 1'b0;
        end else if (end_q) begin
          state_d = STOP;
          scl_d   = 1'b1;
          sda_d   = 1'b1;
        end else begin
          state_d = HOLD;
        end
      end

      BIT: begin
        // Sample on the last cycle of q2, while SCL is high.
        if (q_last && phase_q == 2'd2) begin
          if (bit_q == 4'd8) begin
            if (wr_q && sda_in) err_d = 1'b1;
          end else begin
            rx_d = {rx_q[6:0], sda_in};
          end
        end
        if (q_last) begin
          phase_d = phase_q + 2'd1;
          if (phase_q == 2'd1) scl_d = 1'b0;
          else if (phase_q == 2'd3) begin
            if (bit_q != 4'd8) begin
              bit_d = bit_q + 4'd1;
              tx_d  = {tx_q[6:0], 1'b0};
              scl_d = 1'b1;
              // Next slot is the ACK slot: release on write, ACK unless end on read.
              if (bit_q == 4'd7) sda_d = wr_q ? 1'b0 : ~end_q;
              else               sda_d = wr_q ? ~tx_q[6] : 1'b0;
            end else begin
              if (rd_q) begin
                rdata_d = rx_q;
                rv_d    = 1'b1;
              end
              scl_d = 1'b1;
              if (end_q) begin
                state_d = STOP;
                sda_d   = 1'b1;
              end else begin
                state_d = HOLD;
                sda_d   = 1'b0;
              end
            end
          end
        end
      end

      STOP: if (q_last) begin
        phase_d = phase_q + 2'd1;
        if (phase_q == 2'd0)      scl_d = 1'b0;
        else if (phase_q == 2'd1) sda_d = 1'b0;
        else begin
          state_d = HOLD;
          phase_d = 2'd0;
          open_d  = 1'b0;
        end
      end

      HOLD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK_I2C) begin
    if (RESET) begin
      state_q <= IDLE;
      qcnt_q  <= 16'd0;
      phase_q <= 2'd0;
      bit_q   <= 4'd0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      end_q   <= 1'b0;
      open_q  <= 1'b0;
      tx_q    <= 8'd0;
      rx_q    <= 8'd0;
      rdata_q <= 8'd0;
      scl_q   <= 1'b0;
      sda_q   <= 1'b0;
      err_q   <= 1'b0;
      rv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      qcnt_q  <= qcnt_d;
      phase_q <= phase_d;
      bit_q   <= bit_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      end_q   <= end_d;
      open_q  <= open_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      rdata_q <= rdata_d;
      scl_q   <= scl_d;
      sda_q   <= sda_d;
      err_q   <= err_d;
      rv_q    <= rv_d;
    end
  end

  assign i2c_ready  = (state_q == IDLE);
  assign i2c_error  = err_q;
  assign i2c_rdata  = rdata_q;
  assign i2c_rvalid = rv_q;
  assign scl_oe     = scl_q;
  assign sda_oe     = sda_q;

endmodule

// File: tb/tb_i2c_byte_master.sv
module tb_i2c_byte_master;
  localparam int Q       = 2;
  localparam int STR_LEN = 10;
`ifdef I2C_CLOCK_STRETCH_EN
  localparam int STR_EXTRA = STR_LEN;
`else
  localparam int STR_EXTRA = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] i2c_in = 8'd0;
  logic       i2c_start = 1'b0, i2c_write = 1'b0, i2c_read = 1'b0, i2c_end = 1'b0;
  logic       i2c_ready, i2c_error, i2c_rvalid, scl_oe, sda_oe, scl_in, sda_in;
  logic [7:0] i2c_rdata;
  logic       slave_pull = 1'b0, stretch_pull = 1'b0;

  always #5 clk = ~clk;

  // Wired-AND bus: master and slave can each pull low.
  assign sda_in = ~sda_oe & ~slave_pull;
  assign scl_in = ~scl_oe & ~stretch_pull;

  i2c_byte_master #(.QUARTER(16'(Q))) dut (
    .CLK_I2C(clk), .RESET(rst), .i2c_in(i2c_in),
    .i2c_start(i2c_start), .i2c_write(i2c_write), .i2c_read(i2c_read), .i2c_end(i2c_end),
    .i2c_ready(i2c_ready), .i2c_error(i2c_error), .i2c_rdata(i2c_rdata), .i2c_rvalid(i2c_rvalid),
    .scl_oe(scl_oe), .sda_oe(sda_oe), .scl_in(scl_in), .sda_in(sda_in)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Bus-level model state and per-cycle expectation queues.
  bit         m_open, m_scl, m_sda, m_err, rv_pend;
  logic [7:0] m_rdata;
  bit         e_scl[$], e_sda[$], e_err[$], e_rv[$], s_pull[$], s_str[$];
  logic [7:0] e_rd[$];

  task automatic push_n(input bit scl, input bit sda, input bit pull, input bit str, input int n);
    m_scl = scl;
    m_sda = sda;
    for (int k = 0; k < n; k++) begin
      e_scl.push_back(scl);
      e_sda.push_back(sda);
      e_err.push_back(m_err);
      e_rv.push_back(rv_pend);
      rv_pend = 1'b0;
      e_rd.push_back(m_rdata);
      s_pull.push_back(pull);
      s_str.push_back(str && k == 0);
    end
  endtask

  task automatic push_q(input bit scl, input bit sda, input bit pull, input bit str);
    push_n(scl, sda, pull, str, Q + (str ? STR_EXTRA : 0));
  endtask

  task automatic run_cmd(input bit s, input bit w, input bit r, input bit e,
                         input logic [7:0] d, input logic [7:0] rb, input bit ack,
                         input bit str, input int abort_at,
                         output int busy, output int rvcnt, output logic [15:0] cap);
    bit bw, br, prev_scl, aborted, sb, pb;
    int str_left;
    e_scl.delete(); e_sda.delete(); e_err.delete(); e_rv.delete();
    e_rd.delete(); s_pull.delete(); s_str.delete();
    bw = w;
    br = r & ~w;
    rv_pend = 1'b0;
    if (s) begin
      m_err  = 1'b0;
      m_open = 1'b1;
      push_q(m_scl, 1'b0, 1'b0, 1'b0);
      push_q(1'b0, 1'b0, 1'b0, 1'b0);
      push_q(1'b0, 1'b1, 1'b0, 1'b0);
      push_q(1'b1, 1'b1, 1'b0, 1'b0);
    end
    if ((bw || br) && !m_open) begin
      m_err = 1'b1;
    end else begin
      if (bw || br) begin
        for (int b = 0; b < 9; b++) begin
          if (b < 8) begin
            sb = bw ? ~d[7-b] : 1'b0;
            pb = br ? ~rb[7-b] : 1'b0;
          end else begin
            sb = bw ? 1'b0 : ~e;
            pb = bw ? ack : 1'b0;
          end
          push_q(1'b1, sb, pb, 1'b0);
          push_q(1'b1, sb, pb, 1'b0);
          push_q(1'b0, sb, pb, str && b == 0);
          if (b == 8 && bw && !ack) m_err = 1'b1;
          push_q(1'b0, sb, pb, 1'b0);
        end
        if (br) begin
          rv_pend = 1'b1;
          m_rdata = rb;
        end
        if (!e) begin
          m_scl = 1'b1;
          m_sda = 1'b0;
        end
      end
      if (e && m_open) begin
        push_q(1'b1, 1'b1, 1'b0, 1'b0);
        push_q(1'b0, 1'b1, 1'b0, 1'b0);
        push_q(1'b0, 1'b0, 1'b0, 1'b0);
        m_open = 1'b0;
      end
    end
    push_n(m_scl, m_sda, 1'b0, 1'b0, 1);

    @(negedge clk);
    chk("idle_ready", i2c_ready, 8'd1);
    i2c_start = s; i2c_write = w; i2c_read = r; i2c_end = e; i2c_in = d;
    busy = 0; rvcnt = 0; cap = 16'd0; str_left = 0; prev_scl = scl_oe; aborted = 1'b0;
    for (int i = 0; i < e_scl.size(); i++) begin
      @(negedge clk);
      i2c_start = 1'b0; i2c_write = 1'b0; i2c_read = 1'b0; i2c_end = 1'b0;
      i2c_in = 8'($urandom);
      slave_pull = s_pull[i];
      if (s_str[i]) str_left = STR_LEN;
      stretch_pull = (str_left > 0);
      if (str_left > 0) str_left--;
      if (!i2c_ready) busy++;
      if (i2c_rvalid) rvcnt++;
      if (prev_scl && !scl_oe) cap = {cap[14:0], ~sda_oe};
      prev_scl = scl_oe;
      chk("busy_ready", i2c_ready, 8'd0);
      chk("scl_oe", scl_oe, e_scl[i]);
      chk("sda_oe", sda_oe, e_sda[i]);
      chk("error", i2c_error, e_err[i]);
      chk("rvalid", i2c_rvalid, e_rv[i]);
      chk("rdata", i2c_rdata, e_rd[i]);
      if (i == abort_at) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        slave_pull = 1'b0;
        stretch_pull = 1'b0;
        chk("rst_scl", scl_oe, 8'd0);
        chk("rst_sda", sda_oe, 8'd0);
        chk("rst_ready", i2c_ready, 8'd1);
        chk("rst_error", i2c_error, 8'd0);
        chk("rst_rdata", i2c_rdata, 8'd0);
        chk("rst_rvalid", i2c_rvalid, 8'd0);
        m_open = 1'b0; m_scl = 1'b0; m_sda = 1'b0; m_err = 1'b0; m_rdata = 8'd0;
        aborted = 1'b1;
        break;
      end
    end
    if (!aborted) begin
      @(negedge clk);
      slave_pull = 1'b0;
      stretch_pull = 1'b0;
      chk("ready_back", i2c_ready, 8'd1);
      chk("idle_scl", scl_oe, m_scl);
      chk("idle_sda", sda_oe, m_sda);
      chk("idle_error", i2c_error, m_err);
    end
  endtask

  int busy, rvcnt;
  logic [15:0] cap;
  bit rs, rw, rr, re, rack;

  initial begin
    m_open = 0; m_scl = 0; m_sda = 0; m_err = 0; m_rdata = 8'd0; rv_pend = 0;
    repeat (3) @(negedge clk);
    chk("reset_ready", i2c_ready, 8'd1);
    chk("reset_error", i2c_error, 8'd0);
    chk("reset_rdata", i2c_rdata, 8'd0);
    chk("reset_rvalid", i2c_rvalid, 8'd0);
    chk("reset_scl", scl_oe, 8'd0);
    chk("reset_sda", sda_oe, 8'd0);
    rst = 1'b0;

    // start + write 0x34 + stop, slave ACKs
    run_cmd(1, 1, 0, 1, 8'h34, 8'h00, 1, 0, -1, busy, rvcnt, cap);
    chk("w34_busy", 8'(busy), 8'd87);
    chk("w34_bits", cap[9:2], 8'h34);
    chk("w34_ack_released", cap[1], 8'd1);
    chk("w34_error", i2c_error, 8'd0);

    // NACK on write, stop still issued; next start clears the error
    run_cmd(1, 1, 0, 1, 8'h0C, 8'h00, 0, 0, -1, busy, rvcnt, cap);
    chk("nack_busy", 8'(busy), 8'd87);
    chk("nack_error", i2c_error, 8'd1);
    run_cmd(1, 0, 0, 0, 8'h00, 8'h00, 0, 0, -1, busy, rvcnt, cap);
    chk("start_only_busy", 8'(busy), 8'd9);
    chk("start_clears_error", i2c_error, 8'd0);
    run_cmd(0, 0, 0, 1, 8'h00, 8'h00, 0, 0, -1, busy, rvcnt, cap);
    chk("stop_only_busy", 8'(busy), 8'd7);

    // start + read + end, slave returns 0xA5, master NACKs
    run_cmd(1, 0, 1, 1, 8'h00, 8'hA5, 0, 0, -1, busy, rvcnt, cap);
    chk("read_rdata", i2c_rdata, 8'hA5);
    chk("read_rvalid_pulses", 8'(rvcnt), 8'd1);
    chk("read_nack_released", cap[1], 8'd1);

    // framing: write with no open transaction; stop with no open transaction
    run_cmd(0, 1, 0, 0, 8'h55, 8'h00, 1, 0, -1, busy, rvcnt, cap);
    chk("frame_busy", 8'(busy), 8'd1);
    chk("frame_error", i2c_error, 8'd1);
    chk("frame_scl", scl_oe, 8'd0);
    chk("frame_sda", sda_oe, 8'd0);
    run_cmd(0, 0, 0, 1, 8'h00, 8'h00, 0, 0, -1, busy, rvcnt, cap);
    chk("lone_stop_busy", 8'(busy), 8'd1);
    chk("lone_stop_error_kept", i2c_error, 8'd1);

    // open a transaction with a NACKed byte, then reset during bit 4 of the next write
    run_cmd(1, 1, 0, 0, 8'h5A, 8'h00, 0, 0, -1, busy, rvcnt, cap);
    chk("open_nack_busy", 8'(busy), 8'd81);
    chk("pre_reset_error", i2c_error, 8'd1);
    run_cmd(0, 1, 0, 0, 8'h77, 8'h00, 1, 0, 16 * Q + 1, busy, rvcnt, cap);

    // clock stretching at bit 0 q2
    run_cmd(1, 1, 0, 0, 8'h96, 8'h00, 1, 1, -1, busy, rvcnt, cap);
    chk("stretch_busy", 8'(busy), 8'(81 + STR_EXTRA));
    run_cmd(0, 0, 0, 1, 8'h00, 8'h00, 0, 0, -1, busy, rvcnt, cap);

    // randomized command mix
    for (int t = 0; t < 40; t++) begin
      rs = 1'($urandom_range(0, 1));
      rw = 1'($urandom_range(0, 1));
      rr = 1'($urandom_range(0, 1));
      re = 1'($urandom_range(0, 1));
      rack = ($urandom_range(0, 3) != 0);
      if (!(rs || rw || rr || re)) rs = 1'b1;
      run_cmd(rs, rw, rr, re, 8'($urandom), 8'($urandom), rack, 0, -1, busy, rvcnt, cap);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
